// File: rtl/div_share_arbiter.sv
// Round-robin front end that lets two clients share one sequential divider.
// Captures operands, sequences the divider start, and returns results with a watchdog.
module div_share_arbiter #(
  parameter int W       = 10,
  parameter int TIMEOUT = 48,
  parameter int TW      = 6
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res_q,
  output logic         res_ovf,
  output logic         res_dvz,
  output logic         res_tmo,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_busy,
  input  logic         div_valid,
  input  logic         div_ovf,
  input  logic         div_dvz,
  input  logic [W-1:0] div_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t              state;
  logic                owner;
  logic                last_owner;
  logic [TW-1:0]       cnt;
  logic [1:0][W-1:0]   opa;
  logic [1:0][W-1:0]   opb;
  logic                pick;
  logic                can_grant;
  logic                any_status;
  logic                tmo;

  assign opa        = {a1, a0};
  assign opb        = {b1, b0};
  assign can_grant  = !div_busy && (req0 || req1);
  assign any_status = div_dvz || div_ovf || div_valid;
  assign tmo        = !any_status && (cnt == CNT_LAST);

  // On a tie the requester that did not own the last job wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_owner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      res_q      <= '0;
      res_ovf    <= 1'b0;
      res_dvz    <= 1'b0;
      res_tmo    <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            state      <= ISSUE;
            gnt0       <= ~pick;
            gnt1       <= pick;
            div_start  <= 1'b1;
            div_a      <= opa[pick];
            div_b      <= opb[pick];
            owner      <= pick;
            last_owner <= pick;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (any_status || tmo) begin
            state   <= RESP;
            done0   <= ~owner;
            done1   <= owner;
            res_dvz <= div_dvz;
            res_ovf <= !div_dvz && div_ovf;
            res_tmo <= tmo;
            res_q   <= (div_dvz || tmo) ? '0 : div_q;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: behavioural divider model plus scenario and randomized checks.
module tb_div_share_arbiter;

  localparam int W = 10;
  localparam int TIMEOUT = 48;

  logic clk, rst;
  logic req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic gnt0, gnt1, done0, done1;
  logic [W-1:0] res_q;
  logic res_ovf, res_dvz, res_tmo;
  logic div_start;
  logic [W-1:0] div_a, div_b;
  logic div_busy, div_valid, div_ovf, div_dvz;
  logic [W-1:0] div_q;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // divider model configuration, latched when a start is accepted
  // kind: 0 valid, 1 ovf, 2 dvz, 3 never finishes, 4 ovf+valid, 5 dvz+ovf+valid
  int m_kind = 0;
  int m_lat = 4;
  logic [W-1:0] m_ovfq = '0;

  div_share_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .TW(6)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res_q(res_q), .res_ovf(res_ovf), .res_dvz(res_dvz), .res_tmo(res_tmo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_valid(div_valid), .div_ovf(div_ovf), .div_dvz(div_dvz),
    .div_q(div_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int mcnt, mk, ml;
  logic [W-1:0] ma, mb, mo;

  // Status appears m_lat cycles after the start cycle; busy drops with it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0; div_valid <= 1'b0; div_ovf <= 1'b0; div_dvz <= 1'b0;
      div_q <= '0; mcnt <= 0; mk <= 0; ml <= 0; ma <= '0; mb <= '0; mo <= '0;
    end else begin
      div_valid <= 1'b0; div_ovf <= 1'b0; div_dvz <= 1'b0;
      if (div_start && !div_busy) begin
        div_busy <= 1'b1; mcnt <= 1;
        ma <= div_a; mb <= div_b; mk <= m_kind; ml <= m_lat; mo <= m_ovfq;
      end else if (div_busy) begin
        mcnt <= mcnt + 1;
        if (mcnt + 1 == ml) begin
          div_busy <= 1'b0;
          if (mk == 3) begin
            div_q <= mo;
          end else if (mk == 5) begin
            div_dvz <= 1'b1; div_ovf <= 1'b1; div_valid <= 1'b1; div_q <= mo;
          end else if (mb == 0 || mk == 2) begin
            div_dvz <= 1'b1; div_q <= mo;
          end else if (mk == 1) begin
            div_ovf <= 1'b1; div_q <= mo;
          end else if (mk == 4) begin
            div_ovf <= 1'b1; div_valid <= 1'b1; div_q <= mo;
          end else begin
            div_valid <= 1'b1; div_q <= ma / mb;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input int budget, output int who, output int waited);
    who = -1; waited = 0;
    while (waited < budget && who < 0) begin
      @(negedge clk); waited++;
      if (gnt0) who = 0; else if (gnt1) who = 1;
    end
  endtask

  task automatic wait_done(input int budget, output int who);
    int n;
    who = -1; n = 0;
    while (n < budget && who < 0) begin
      @(negedge clk); n++;
      if (done0) who = 0; else if (done1) who = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, div_start, res_ovf, res_dvz, res_tmo, res_q, div_a, div_b} !== '0) begin
      errors++; $display("FAIL reset_state: outputs not all zero while rst held");
    end
    rst = 1'b0; req0 = 1'b1; a0 = 10'h055; b0 = 10'h003; m_kind = 0; m_lat = 4;
    @(posedge clk); #2;
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL reset_pre_gnt: gnt0=%b want 1", gnt0); end
    rst = 1'b1; #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, div_start, res_q, div_a, div_b} !== '0) begin
      errors++; $display("FAIL reset_async: gnt0=%b start=%b div_a=%h want all 0", gnt0, div_start, div_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b0 || div_start !== 1'b0) begin
        errors++; $display("FAIL reset_no_gnt: gnt0=%b start=%b want 0 during rst", gnt0, div_start);
      end
    end
    req0 = 1'b0; rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0 || done1 || gnt0 || gnt1) begin
        checks++; errors++; $display("FAIL reset_quiet: gnt=%b%b done=%b%b want 0", gnt1, gnt0, done1, done0);
      end
    end
  endtask

  task automatic test_single();
    int who, waited, g;
    do_reset();
    req0 = 1'b1; a0 = 10'h0C8; b0 = 10'h005; m_kind = 0; m_lat = 12;
    wait_gnt(20, who, waited);
    g = cyc;
    checks++;
    if (who != 0 || waited != 1 || div_start !== 1'b1) begin
      errors++; $display("FAIL single_gnt: who=%0d after %0d cyc start=%b want 0 after 1 start=1", who, waited, div_start);
    end
    checks++;
    if (div_a !== 10'h0C8 || div_b !== 10'h005) begin
      errors++; $display("FAIL single_ops: div_a=%h div_b=%h want 0c8 005", div_a, div_b);
    end
    req0 = 1'b0;
    wait_done(100, who);
    checks++;
    if (who != 0 || done1 !== 1'b0 || cyc - g != 13) begin
      errors++; $display("FAIL single_done: who=%0d lat=%0d want 0 lat=13", who, cyc - g);
    end
    checks++;
    if (res_q !== 10'h028 || {res_ovf, res_dvz, res_tmo} !== 3'b000) begin
      errors++; $display("FAIL single_res: q=%h flags=%b%b%b want 028 000", res_q, res_ovf, res_dvz, res_tmo);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || res_q !== 10'h028) begin
      errors++; $display("FAIL single_hold: done0=%b q=%h want 0 028", done0, res_q);
    end
  endtask

  task automatic test_fairness();
    int who, waited, dwho, last_done;
    do_reset();
    req0 = 1'b1; a0 = 10'h100; b0 = 10'h004;
    req1 = 1'b1; a1 = 10'h0FF; b1 = 10'h011;
    m_kind = 0; m_lat = 5; last_done = 0;
    for (int j = 0; j < 4; j++) begin
      wait_gnt(100, who, waited);
      checks++;
      if (who != j % 2 || (gnt0 && gnt1)) begin
        errors++; $display("FAIL fair_order: job %0d gnt=%b%b want owner %0d", j, gnt1, gnt0, j % 2);
      end
      if (j > 0) begin
        checks++;
        if (cyc - last_done != 2) begin
          errors++; $display("FAIL fair_spacing: done->gnt %0d cyc want 2", cyc - last_done);
        end
      end
      wait_done(100, dwho);
      last_done = cyc;
      checks++;
      if (dwho != j % 2 || (done0 && done1) || res_q !== ((j % 2 == 0) ? 10'd64 : 10'd15)) begin
        errors++; $display("FAIL fair_done: job %0d done=%b%b q=%0d want owner %0d", j, done1, done0, res_q, j % 2);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_exceptions();
    int who, waited;
    req1 = 1'b1; a1 = 10'h123; b1 = 10'h000; m_kind = 2; m_lat = 6; m_ovfq = 10'h2AA;
    wait_gnt(20, who, waited);
    checks++;
    if (who != 1) begin errors++; $display("FAIL exc_dvz_gnt: who=%0d want 1", who); end
    req1 = 1'b0;
    wait_done(100, who);
    checks++;
    if (who != 1 || res_q !== '0 || {res_ovf, res_dvz, res_tmo} !== 3'b010) begin
      errors++; $display("FAIL exc_dvz: who=%0d q=%h flags=%b%b%b want 1 000 010", who, res_q, res_ovf, res_dvz, res_tmo);
    end
    req0 = 1'b1; a0 = 10'h200; b0 = 10'h001; m_kind = 1; m_lat = 3; m_ovfq = 10'h3FF;
    wait_gnt(20, who, waited);
    req0 = 1'b0;
    wait_done(100, who);
    checks++;
    if (who != 0 || res_q !== 10'h3FF || {res_ovf, res_dvz, res_tmo} !== 3'b100) begin
      errors++; $display("FAIL exc_ovf: who=%0d q=%h flags=%b%b%b want 0 3ff 100", who, res_q, res_ovf, res_dvz, res_tmo);
    end
    req1 = 1'b1; a1 = 10'h040; b1 = 10'h002; m_kind = 5; m_lat = 4; m_ovfq = 10'h155;
    wait_gnt(20, who, waited);
    req1 = 1'b0;
    wait_done(100, who);
    checks++;
    if (res_q !== '0 || {res_ovf, res_dvz, res_tmo} !== 3'b010) begin
      errors++; $display("FAIL exc_prio_dvz: q=%h flags=%b%b%b want 000 010", res_q, res_ovf, res_dvz, res_tmo);
    end
    req0 = 1'b1; a0 = 10'h040; b0 = 10'h002; m_kind = 4; m_lat = 4; m_ovfq = 10'h155;
    wait_gnt(20, who, waited);
    req0 = 1'b0;
    wait_done(100, who);
    checks++;
    if (res_q !== 10'h155 || {res_ovf, res_dvz, res_tmo} !== 3'b100) begin
      errors++; $display("FAIL exc_prio_ovf: q=%h flags=%b%b%b want 155 100", res_q, res_ovf, res_dvz, res_tmo);
    end
  endtask

  task automatic test_timeout();
    int who, waited, g;
    req0 = 1'b1; a0 = 10'h3C0; b0 = 10'h003; m_kind = 3; m_lat = 60; m_ovfq = 10'h1A5;
    wait_gnt(20, who, waited);
    g = cyc;
    req0 = 1'b0;
    @(negedge clk);
    m_kind = 0; m_lat = 4;
    repeat (3) @(negedge clk);
    req1 = 1'b1; a1 = 10'h064; b1 = 10'h00A;
    wait_done(200, who);
    checks++;
    if (who != 0 || cyc - g != TIMEOUT + 1) begin
      errors++; $display("FAIL tmo_done: who=%0d lat=%0d want 0 lat=%0d", who, cyc - g, TIMEOUT + 1);
    end
    checks++;
    if (res_q !== '0 || {res_ovf, res_dvz, res_tmo} !== 3'b001) begin
      errors++; $display("FAIL tmo_res: q=%h flags=%b%b%b want 000 001", res_q, res_ovf, res_dvz, res_tmo);
    end
    wait_gnt(100, who, waited);
    checks++;
    if (who != 1 || cyc - g != 61 || div_busy !== 1'b0) begin
      errors++; $display("FAIL tmo_regrant: who=%0d at %0d busy=%b want 1 at 61 busy=0", who, cyc - g, div_busy);
    end
    req1 = 1'b0;
    wait_done(100, who);
    checks++;
    if (who != 1 || res_q !== 10'h00A || res_tmo !== 1'b0) begin
      errors++; $display("FAIL tmo_next: who=%0d q=%h tmo=%b want 1 00a 0", who, res_q, res_tmo);
    end
  endtask

  task automatic test_reset_wait();
    int who, waited;
    do_reset();
    req0 = 1'b1; a0 = 10'h111; b0 = 10'h002; m_kind = 3; m_lat = 60;
    wait_gnt(20, who, waited);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; req1 = 1'b1; a1 = 10'h3E8; b1 = 10'h019; m_kind = 0; m_lat = 3;
    @(negedge clk);
    checks++;
    if ({done0, done1, gnt0, gnt1, div_busy} !== 5'b0) begin
      errors++; $display("FAIL rstwait_clear: done=%b%b gnt=%b%b busy=%b want 0", done1, done0, gnt1, gnt0, div_busy);
    end
    rst = 1'b0;
    wait_gnt(20, who, waited);
    checks++;
    if (who != 1 || waited != 1) begin
      errors++; $display("FAIL rstwait_gnt: who=%0d after %0d want 1 after 1", who, waited);
    end
    req1 = 1'b0;
    wait_done(100, who);
    checks++;
    if (who != 1 || res_q !== 10'h028) begin
      errors++; $display("FAIL rstwait_done: who=%0d q=%h want 1 028", who, res_q);
    end
  endtask

  task automatic test_random();
    int left[2], gap[2];
    logic rq[2];
    logic [W-1:0] ca[2], cb[2];
    logic [1:0] req_edge;
    int last_w, infl, inf_w, inf_kind, inf_lat, inf_g, ndone, w, exp_w, cycles;
    logic [W-1:0] inf_a, inf_b, inf_o, eq;
    logic edvz, eovf;
    int kinds[4];
    kinds[0] = 0; kinds[1] = 1; kinds[2] = 4; kinds[3] = 5;
    do_reset();
    last_w = 1; left[0] = 12; left[1] = 12; gap[0] = 0; gap[1] = 0;
    rq[0] = 1'b0; rq[1] = 1'b0; ca[0] = '0; ca[1] = '0; cb[0] = '0; cb[1] = '0;
    infl = 0; ndone = 0; cycles = 0; req_edge = 2'b00;
    inf_w = 0; inf_kind = 0; inf_lat = 0; inf_g = 0; inf_a = '0; inf_b = '0; inf_o = '0;
    while (ndone < 24 && cycles < 4000) begin
      @(negedge clk); cycles++;
      if (gnt0 || gnt1) begin
        w = gnt1 ? 1 : 0;
        exp_w = (req_edge == 2'b11) ? 1 - last_w : (req_edge[1] ? 1 : 0);
        checks++;
        if ((gnt0 && gnt1) || w != exp_w || infl != 0) begin
          errors++; $display("FAIL rnd_grant: gnt=%b%b reqs=%b want owner %0d", gnt1, gnt0, req_edge, exp_w);
        end
        checks++;
        if (div_a !== ca[w] || div_b !== cb[w] || div_start !== 1'b1) begin
          errors++; $display("FAIL rnd_ops: div_a=%h div_b=%h want %h %h", div_a, div_b, ca[w], cb[w]);
        end
        infl = 1; inf_w = w; inf_a = ca[w]; inf_b = cb[w]; inf_g = cyc;
        inf_kind = kinds[$urandom_range(0, 3)]; inf_lat = $urandom_range(2, 20);
        inf_o = W'($urandom());
        m_kind = inf_kind; m_lat = inf_lat; m_ovfq = inf_o;
        last_w = w; left[w]--; gap[w] = $urandom_range(0, 2); rq[w] = 1'b0;
      end
      if (done0 || done1) begin
        edvz = (inf_kind == 5) || (inf_b == '0);
        eovf = !edvz && (inf_kind == 1 || inf_kind == 4);
        if (edvz) eq = '0;
        else if (eovf) eq = inf_o;
        else eq = inf_a / inf_b;
        checks++;
        if ((done0 && done1) || (done1 ? 1 : 0) != inf_w || infl == 0) begin
          errors++; $display("FAIL rnd_done_owner: done=%b%b want owner %0d", done1, done0, inf_w);
        end
        checks++;
        if (res_q !== eq || res_dvz !== edvz || res_ovf !== eovf || res_tmo !== 1'b0) begin
          errors++; $display("FAIL rnd_result: q=%h ovf=%b dvz=%b tmo=%b want %h %b %b 0", res_q, res_ovf, res_dvz, res_tmo, eq, eovf, edvz);
        end
        checks++;
        if (cyc - inf_g != inf_lat + 1) begin
          errors++; $display("FAIL rnd_latency: %0d want %0d", cyc - inf_g, inf_lat + 1);
        end
        infl = 0; ndone++;
      end
      if (div_start) begin
        checks++;
        if (div_busy) begin errors++; $display("FAIL rnd_start_busy: div_start=1 div_busy=1 want busy 0"); end
      end
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] && left[i] > 0) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            ca[i] = W'($urandom());
            cb[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom());
            rq[i] = 1'b1;
          end
        end
      end
      req0 = rq[0]; a0 = ca[0]; b0 = cb[0];
      req1 = rq[1]; a1 = ca[1]; b1 = cb[1];
      req_edge = {rq[1], rq[0]};
    end
    checks++;
    if (ndone != 24) begin errors++; $display("FAIL rnd_complete: %0d jobs done want 24", ndone); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_fairness();
    test_exceptions();
    test_timeout();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
